// File: rtl/rob_param_queue.sv
// Circular reorder buffer: in-order allocate at tail, tag-matched CDB capture,
// in-order commit at head with valid/ready handshake, and single-cycle flush.
module rob_param_queue #(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 6,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int DEST_W  = 5,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        alloc_valid,
    output logic                        alloc_ready,
    input  logic [DEST_W-1:0]           alloc_dest,
    input  logic [TAG_W-1:0]            alloc_tag,
    output logic [PTR_W-1:0]            alloc_idx,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    output logic                        commit_valid,
    input  logic                        commit_ready,
    output logic [DEST_W-1:0]           commit_dest,
    output logic [DATA_W-1:0]           commit_data,
    output logic [TAG_W-1:0]            commit_tag,
    output logic [DEPTH-1:0]            entry_busy,
    output logic [PTR_W:0]              count,
    output logic                        full,
    output logic                        empty
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEST_W-1:0] dest_q  [DEPTH];
    logic [DEST_W-1:0] dest_d  [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];
    logic [TAG_W-1:0]  tag_d   [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;

    logic do_alloc;
    logic do_commit;

    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign alloc_ready  = ~full;
    assign alloc_idx    = tail_q;
    assign entry_busy   = busy_q;
    assign commit_valid = busy_q[head_q] & done_q[head_q];
    assign commit_dest  = commit_valid ? dest_q[head_q]  : '0;
    assign commit_data  = commit_valid ? value_q[head_q] : '0;
    assign commit_tag   = commit_valid ? tag_q[head_q]   : '0;
    assign do_alloc     = alloc_valid & ~full;
    assign do_commit    = commit_valid & commit_ready;

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        dest_d  = dest_q;
        tag_d   = tag_q;
        value_d = value_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // Channels scanned high-to-low so the lowest matching channel is written last.
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (busy_q[e] && !done_q[e] && tag_q[e] != '0) begin
                for (int unsigned k = 0; k < NUM_CDB; k++) begin
                    if (cdb_valid[NUM_CDB-1-k] &&
                        cdb_tag[(NUM_CDB-1-k)*TAG_W +: TAG_W] == tag_q[e]) begin
                        done_d[e]  = 1'b1;
                        value_d[e] = cdb_data[(NUM_CDB-1-k)*DATA_W +: DATA_W];
                    end
                end
            end
        end

        if (do_commit) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d = (head_q == LAST_IDX) ? '0 : head_q + 1'b1;
        end

        // Tail entry is never busy when not full, so capture cannot hit it this cycle.
        if (do_alloc) begin
            busy_d[tail_q]  = 1'b1;
            done_d[tail_q]  = 1'b0;
            dest_d[tail_q]  = alloc_dest;
            tag_d[tail_q]   = alloc_tag;
            value_d[tail_q] = '0;
            tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + 1'b1;
        end

        case ({do_alloc, do_commit})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            for (int unsigned e = 0; e < DEPTH; e++) begin
                dest_d[e]  = '0;
                tag_d[e]   = '0;
                value_d[e] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned e = 0; e < DEPTH; e++) begin
                dest_q[e]  <= '0;
                tag_q[e]   <= '0;
                value_q[e] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dest_q  <= dest_d;
            tag_q   <= tag_d;
            value_q <= value_d;
        end
    end

endmodule
